wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the cycles without s_ack_i before a granted master is faulted; legal range 2..65535.
REQ-002 clk_i  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst_i  in  1  reset; asynchronous, active-high.
REQ-004 m0_cyc_i, m1_cyc_i  in  1  per-master bus request (Wishbone CYC).
REQ-005 m0_stb_i, m1_stb_i  in  1  per-master strobe.
REQ-006 m0_we_i, m1_we_i  in  1  per-master write enable.
REQ-007 m0_sel_i, m1_sel_i  in  4  per-master byte selects.
REQ-008 m0_adr_i, m1_adr_i  in  32  per-master address.
REQ-009 m0_dat_i, m1_dat_i  in  32  per-master write data.
REQ-010 m0_stall_o, m1_stall_o  out  1  per-master stall.
REQ-011 m0_ack_o, m1_ack_o  out  1  per-master acknowledge.
REQ-012 m0_err_o, m1_err_o  out  1  per-master timeout error, one-cycle pulse.
REQ-013 m0_dat_o, m1_dat_o  out  32  read data, both SHALL equal s_dat_i at all times.
REQ-014 s_cyc_o, s_stb_o, s_we_o  out  1 each  shared-bus cycle, strobe, write enable.
REQ-015 s_sel_o  out  4; s_adr_o, s_dat_o  out  32  shared-bus selects, address, write data.
REQ-016 s_stall_i, s_ack_i  in  1 each; s_dat_i  in  32  shared-bus stall, ack, read data.

Function
REQ-017 States SHALL be IDLE, OWN, FAULT; registers: state, owner (1 bit), last_owner (1 bit), timeout counter of ceil(log2(TIMEOUT+1)) bits.
REQ-018 IDLE: s_cyc_o, s_stb_o, s_we_o = 0, s_sel_o = 0, s_adr_o = 0, s_dat_o = 0; both stall_o = 1; all ack_o/err_o = 0.
REQ-019 IDLE arbitration: only m0_cyc_i -> owner 0; only m1_cyc_i -> owner 1; both -> owner = ~last_owner (round-robin); next state OWN; neither -> stay IDLE.
REQ-020 Arbitration latency SHALL be exactly one cycle: request sampled in IDLE, bus driven from the following (OWN) cycle.
REQ-021 OWN: s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o SHALL combinationally mirror the owner's inputs.
REQ-022 OWN: owner stall_o = s_stall_i, owner ack_o = s_ack_i & owner cyc; non-owner stall_o = 1, ack_o = 0, err_o = 0.
REQ-023 OWN, owner cyc = 0: s_cyc_o = s_stb_o = 0 that cycle, s_ack_i ignored, last_owner <= owner, next state IDLE (one dead cycle between grants).
REQ-024 Counter SHALL clear on entry to OWN and on any cycle with s_ack_i = 1; otherwise increment each OWN cycle with owner cyc = 1, saturating at TIMEOUT.
REQ-025 OWN, counter == TIMEOUT and s_ack_i = 0: owner err_o = 1, owner ack_o = 0, s_cyc_o = s_stb_o = 0 that cycle, last_owner <= owner, next state FAULT.
REQ-026 Simultaneous s_ack_i and timeout: ack SHALL win; no err, counter clears.
REQ-027 FAULT: shared-bus outputs as IDLE, both stall_o = 1, no ack/err; exit to IDLE only when faulted owner's cyc_i = 0; other master's request waits.
REQ-028 A master SHALL never see ack_o and err_o high in the same cycle; at most one master's ack_o/err_o high per cycle.

Reset
REQ-029 rst_i high SHALL immediately (asynchronously) force state IDLE, owner 0, last_owner 1, counter 0, so m0 wins the first contested arbitration.
REQ-030 Reset mid-transaction SHALL drop s_cyc_o/s_stb_o at once with no ack/err issued; outputs as REQ-018 until released.

Verification
REQ-031 Post-reset, m0 and m1 assert cyc same cycle -> m0 granted next cycle; m0 drops cyc -> one IDLE cycle -> m1 granted.
REQ-032 m1 read, s_stall_i = 1 for 3 cycles then ack with s_dat_i = 0xDEADBEEF -> m1_stall_o follows, m1_ack_o one cycle, m1_dat_o = 0xDEADBEEF, m0 stalled throughout.
REQ-033 m0 byte write sel 4'b0100, adr 0x1002, dat 0x00AB0000 -> identical values on s_* during OWN; m0_ack_o on s_ack_i.
REQ-034 TIMEOUT = 4, m0 holds cyc with no ack -> m0_err_o pulses in 5th OWN cycle, s_cyc_o low; stays FAULT until m0_cyc_i = 0.
REQ-035 TIMEOUT = 4, s_ack_i arrives in 5th OWN cycle -> m0_ack_o = 1, no err, counter clears.
REQ-036 rst_i asserted mid-stall of an m1 transfer -> s_cyc_o = 0 same cycle, no ack/err, next contested grant goes to m0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter with round-robin grant on contention and a
// per-grant acknowledge watchdog that faults a master whose slave goes silent.
module wb_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_stall_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_stall_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_stall_i,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i
);

    localparam int unsigned    CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, OWN, FAULT} state_t;

    state_t        state, state_nxt;
    logic          owner, owner_nxt;
    logic          last_owner, last_owner_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    // Owner-selected request signals
    logic        o_cyc, o_stb, o_we;
    logic [3:0]  o_sel;
    logic [31:0] o_adr, o_dat;
    logic        g_stall, g_ack, g_err;

    assign o_cyc = owner ? m1_cyc_i : m0_cyc_i;
    assign o_stb = owner ? m1_stb_i : m0_stb_i;
    assign o_we  = owner ? m1_we_i  : m0_we_i;
    assign o_sel = owner ? m1_sel_i : m0_sel_i;
    assign o_adr = owner ? m1_adr_i : m0_adr_i;
    assign o_dat = owner ? m1_dat_i : m0_dat_i;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // State, grant and watchdog registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            cnt        <= cnt_nxt;
        end
    end

    // Arbitration, watchdog and shared-bus muxing
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        cnt_nxt        = cnt;
        s_cyc_o        = 1'b0;
        s_stb_o        = 1'b0;
        s_we_o         = 1'b0;
        s_sel_o        = '0;
        s_adr_o        = '0;
        s_dat_o        = '0;
        g_stall        = 1'b1;
        g_ack          = 1'b0;
        g_err          = 1'b0;
        case (state)
            IDLE: begin
                if (m0_cyc_i || m1_cyc_i) begin
                    state_nxt = OWN;
                    cnt_nxt   = '0;
                    if (m0_cyc_i && m1_cyc_i) owner_nxt = ~last_owner;
                    else                      owner_nxt = m1_cyc_i;
                end
            end
            OWN: begin
                s_cyc_o = o_cyc;
                s_stb_o = o_stb;
                s_we_o  = o_we;
                s_sel_o = o_sel;
                s_adr_o = o_adr;
                s_dat_o = o_dat;
                g_stall = s_stall_i;
                // Release beats ack; ack beats the watchdog expiring
                if (!o_cyc) begin
                    last_owner_nxt = owner;
                    state_nxt      = IDLE;
                end else if (s_ack_i) begin
                    g_ack   = 1'b1;
                    cnt_nxt = '0;
                end else if (cnt == TO_MAX) begin
                    s_cyc_o        = 1'b0;
                    s_stb_o        = 1'b0;
                    g_err          = 1'b1;
                    last_owner_nxt = owner;
                    state_nxt      = FAULT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            FAULT: begin
                if (!o_cyc) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Route grant responses to the owning master only
    always_comb begin
        m0_stall_o = 1'b1;
        m1_stall_o = 1'b1;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_err_o   = 1'b0;
        if (state == OWN) begin
            if (owner) begin
                m1_stall_o = g_stall;
                m1_ack_o   = g_ack;
                m1_err_o   = g_err;
            end else begin
                m0_stall_o = g_stall;
                m0_ack_o   = g_ack;
                m0_err_o   = g_err;
            end
        end
    end

endmodule
